// File: rtl/id_ex_hazard_pipe.sv
// ID/EX control register with load-use stall and counted jump flush; 1-cycle ID->EX latency.
// Stall drops pc_write/ifid_write for exactly one cycle; a flush keeps fetching while bubbles fill EX.
module id_ex_hazard_pipe #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             RegDst,
    input  logic [3:0]       ALUOp,
    input  logic             ALUSrc,
    input  logic [1:0]       Jump,
    input  logic             J_Jump,
    input  logic             MemRead,
    input  logic             RegWrite,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic             uses_rt,
    input  logic             jump_taken,
    output logic             RegDst_o,
    output logic [3:0]       ALUOp_o,
    output logic             ALUSrc_o,
    output logic [1:0]       Jump_o,
    output logic             J_Jump_o,
    output logic             MemRead_o,
    output logic             RegWrite_o,
    output logic [4:0]       rt_o,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             bubble_o,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef struct packed {
        logic       regdst;
        logic [3:0] aluop;
        logic       alusrc;
        logic [1:0] jump;
        logic       j_jump;
        logic       memread;
        logic       regwrite;
        logic [4:0] rt;
    } ctrl_t;

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t           state_q;
    logic [2:0]       flush_cnt_q;
    ctrl_t            ctrl_q, ctrl_d, ctrl_in;
    logic             bubble_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hazard, stall, load_bubble;

    assign ctrl_in = '{regdst: RegDst, aluop: ALUOp, alusrc: ALUSrc, jump: Jump,
                       j_jump: J_Jump, memread: MemRead, regwrite: RegWrite, rt: rt};

    // The ID/EX load's destination feeding either source of the ID instruction.
    assign hazard = ctrl_q.memread & ctrl_q.regwrite & (ctrl_q.rt != 5'd0) &
                    ((ctrl_q.rt == rs) | (uses_rt & (ctrl_q.rt == rt)));

    // A taken jump outranks the stall: the stalled instruction is squashed anyway.
    assign stall       = (state_q == RUN) & hazard & ~jump_taken;
    assign load_bubble = (state_q == FLUSH) | jump_taken | hazard;
    assign pc_write    = ~stall;
    assign ifid_write  = ~stall;

    assign ctrl_d = load_bubble ? '0 : ctrl_in;
    assign cnt_d  = (load_bubble && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            flush_cnt_q <= 3'd0;
            ctrl_q      <= '0;
            bubble_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            bubble_q <= load_bubble;
            cnt_q    <= cnt_d;
            case (state_q)
                RUN: begin
                    if (jump_taken && (FLUSH_CYCLES > 1)) begin
                        state_q     <= FLUSH;
                        flush_cnt_q <= 3'(FLUSH_CYCLES - 1);
                    end
                end
                FLUSH: begin
                    // Counter holds the bubbles still owed; leave when the last one is loaded.
                    flush_cnt_q <= flush_cnt_q - 3'd1;
                    if (flush_cnt_q == 3'd1) begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign RegDst_o   = ctrl_q.regdst;
    assign ALUOp_o    = ctrl_q.aluop;
    assign ALUSrc_o   = ctrl_q.alusrc;
    assign Jump_o     = ctrl_q.jump;
    assign J_Jump_o   = ctrl_q.j_jump;
    assign MemRead_o  = ctrl_q.memread;
    assign RegWrite_o = ctrl_q.regwrite;
    assign rt_o       = ctrl_q.rt;
    assign bubble_o   = bubble_q;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_pipe.sv
// Bench for id_ex_hazard_pipe: vector table with scoreboard plus hand-written reset corner cases.
module tb_id_ex_hazard_pipe;

    logic       clk, rst_n;
    logic       RegDst, ALUSrc, J_Jump, MemRead, RegWrite, uses_rt, jump_taken;
    logic [3:0] ALUOp;
    logic [1:0] Jump;
    logic [4:0] rs, rt;

    logic        RegDst_o, ALUSrc_o, J_Jump_o, MemRead_o, RegWrite_o, pc_write, ifid_write, bubble_o;
    logic [3:0]  ALUOp_o;
    logic [1:0]  Jump_o;
    logic [4:0]  rt_o;
    logic [15:0] bubble_cnt;

    logic        s_RegDst_o, s_ALUSrc_o, s_J_Jump_o, s_MemRead_o, s_RegWrite_o, s_pc_write, s_ifid_write, s_bubble_o;
    logic [3:0]  s_ALUOp_o;
    logic [1:0]  s_Jump_o;
    logic [4:0]  s_rt_o;
    logic [1:0]  s_bubble_cnt;

    id_ex_hazard_pipe #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .RegDst(RegDst), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .Jump(Jump),
        .J_Jump(J_Jump), .MemRead(MemRead), .RegWrite(RegWrite), .rs(rs), .rt(rt), .uses_rt(uses_rt),
        .jump_taken(jump_taken), .RegDst_o(RegDst_o), .ALUOp_o(ALUOp_o), .ALUSrc_o(ALUSrc_o),
        .Jump_o(Jump_o), .J_Jump_o(J_Jump_o), .MemRead_o(MemRead_o), .RegWrite_o(RegWrite_o),
        .rt_o(rt_o), .pc_write(pc_write), .ifid_write(ifid_write), .bubble_o(bubble_o),
        .bubble_cnt(bubble_cnt)
    );

    // Narrow counter copy, driven identically, to observe saturation.
    id_ex_hazard_pipe #(.FLUSH_CYCLES(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .RegDst(RegDst), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .Jump(Jump),
        .J_Jump(J_Jump), .MemRead(MemRead), .RegWrite(RegWrite), .rs(rs), .rt(rt), .uses_rt(uses_rt),
        .jump_taken(jump_taken), .RegDst_o(s_RegDst_o), .ALUOp_o(s_ALUOp_o), .ALUSrc_o(s_ALUSrc_o),
        .Jump_o(s_Jump_o), .J_Jump_o(s_J_Jump_o), .MemRead_o(s_MemRead_o), .RegWrite_o(s_RegWrite_o),
        .rt_o(s_rt_o), .pc_write(s_pc_write), .ifid_write(s_ifid_write), .bubble_o(s_bubble_o),
        .bubble_cnt(s_bubble_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] aluop;
        logic       memread, regwrite;
        logic [4:0] rs, rt;
        logic       uses_rt, jt;
        logic       exp_pcw, exp_bub;
        int         exp_cnt;
    } vec_t;

    typedef struct {
        logic [16:0] bundle;
        logic [15:0] cnt;
        logic [1:0]  scnt;
        int          row;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];
    int   checks = 0;
    int   fails  = 0;

    function automatic vec_t v(input logic [3:0] aluop, input logic mr, input logic rw,
                               input logic [4:0] rs_v, input logic [4:0] rt_v, input logic ur,
                               input logic jt, input logic pcw, input logic bub, input int cnt);
        vec_t r;
        r.aluop = aluop; r.memread = mr; r.regwrite = rw; r.rs = rs_v; r.rt = rt_v;
        r.uses_rt = ur; r.jt = jt; r.exp_pcw = pcw; r.exp_bub = bub; r.exp_cnt = cnt;
        return r;
    endfunction

    function automatic logic [16:0] dut_bundle();
        return {RegDst_o, ALUOp_o, ALUSrc_o, Jump_o, J_Jump_o, MemRead_o, RegWrite_o, rt_o, bubble_o};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        ALUOp = r.aluop; RegDst = r.aluop[0]; ALUSrc = r.aluop[1]; Jump = r.aluop[3:2];
        J_Jump = r.aluop[0] ^ r.aluop[3]; MemRead = r.memread; RegWrite = r.regwrite;
        rs = r.rs; rt = r.rt; uses_rt = r.uses_rt; jump_taken = r.jt;
    endtask

    task automatic run_row(input vec_t r, input int idx);
        exp_t e;
        exp_t got;
        drive(r);
        e.row  = idx;
        e.cnt  = 16'(r.exp_cnt);
        e.scnt = (r.exp_cnt > 3) ? 2'd3 : 2'(r.exp_cnt);
        e.bundle = r.exp_bub ? 17'h1
                 : {RegDst, ALUOp, ALUSrc, Jump, J_Jump, MemRead, RegWrite, rt, 1'b0};
        sbq.push_back(e);
        @(negedge clk);
        chk($sformatf("row%0d pc_write", idx), {31'd0, pc_write}, {31'd0, r.exp_pcw});
        chk($sformatf("row%0d ifid_write", idx), {31'd0, ifid_write}, {31'd0, r.exp_pcw});
        @(posedge clk);
        #1;
        got = sbq.pop_front();
        chk($sformatf("row%0d idex", got.row), {15'd0, dut_bundle()}, {15'd0, got.bundle});
        chk($sformatf("row%0d bubble_cnt", got.row), {16'd0, bubble_cnt}, {16'd0, got.cnt});
        chk($sformatf("row%0d sat_cnt", got.row), {30'd0, s_bubble_cnt}, {30'd0, got.scnt});
    endtask

    initial begin
        // aluop, memread, regwrite, rs, rt, uses_rt, jump_taken, exp pc_write, exp bubble, exp count
        vecs.push_back(v(4'hA, 0, 0,  1,  2, 0, 0, 1, 0, 0)); // first capture after reset
        vecs.push_back(v(4'h2, 1, 1,  3,  8, 0, 0, 1, 0, 0)); // load r8
        vecs.push_back(v(4'h5, 0, 1,  8,  4, 0, 0, 0, 1, 1)); // rs uses r8: stall
        vecs.push_back(v(4'h5, 0, 1,  8,  4, 0, 0, 1, 0, 1)); // held instruction passes
        vecs.push_back(v(4'h4, 1, 1,  0,  0, 0, 0, 1, 0, 1)); // load r0
        vecs.push_back(v(4'h1, 0, 1,  0,  0, 1, 0, 1, 0, 1)); // r0 never hazards
        vecs.push_back(v(4'h2, 1, 1,  4,  9, 0, 0, 1, 0, 1)); // load r9
        vecs.push_back(v(4'h3, 0, 1,  1,  9, 0, 0, 1, 0, 1)); // rt matches, uses_rt=0
        vecs.push_back(v(4'h2, 1, 1,  4,  9, 0, 0, 1, 0, 1)); // load r9
        vecs.push_back(v(4'h3, 0, 1,  1,  9, 1, 0, 0, 1, 2)); // rt matches, uses_rt=1: stall
        vecs.push_back(v(4'h3, 0, 1,  1,  9, 1, 0, 1, 0, 2));
        vecs.push_back(v(4'h6, 0, 1,  2,  3, 0, 1, 1, 1, 3)); // jump: flush bubble 1
        vecs.push_back(v(4'h7, 0, 1,  2,  3, 0, 1, 1, 1, 4)); // flush bubble 2, jump ignored
        vecs.push_back(v(4'h8, 0, 1,  2,  3, 0, 0, 1, 0, 4)); // normal capture
        vecs.push_back(v(4'h2, 1, 1,  4, 10, 0, 0, 1, 0, 4)); // load r10
        vecs.push_back(v(4'h9, 0, 1, 10,  3, 0, 1, 1, 1, 5)); // hazard + jump: flush wins
        vecs.push_back(v(4'h9, 0, 1, 10,  3, 0, 0, 1, 1, 6));
        vecs.push_back(v(4'hB, 0, 1, 10,  3, 0, 0, 1, 0, 6)); // no extra stall bubble

        rst_n = 1'b0;
        ALUOp = 4'($urandom); RegDst = 1'($urandom); ALUSrc = 1'($urandom); Jump = 2'($urandom);
        J_Jump = 1'($urandom); MemRead = 1'($urandom); RegWrite = 1'($urandom);
        rs = 5'($urandom); rt = 5'($urandom); uses_rt = 1'($urandom); jump_taken = 1'($urandom);
        repeat (3) @(posedge clk);
        #1;
        chk("reset idex", {15'd0, dut_bundle()}, 32'd0);
        chk("reset bubble_cnt", {16'd0, bubble_cnt}, 32'd0);
        chk("reset pc_write", {31'd0, pc_write}, 32'd1);
        rst_n = 1'b1;

        foreach (vecs[i]) run_row(vecs[i], i);

        // Asynchronous reset in the middle of a flush.
        drive(v(4'h6, 0, 1, 2, 3, 0, 1, 1, 1, 7));
        @(posedge clk);
        #1;
        chk("flush entry bubble", {31'd0, bubble_o}, 32'd1);
        drive(v(4'h5, 1, 1, 2, 3, 0, 0, 1, 0, 0));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async reset idex", {15'd0, dut_bundle()}, 32'd0);
        chk("async reset bubble_cnt", {16'd0, bubble_cnt}, 32'd0);
        chk("async reset sat_cnt", {30'd0, s_bubble_cnt}, 32'd0);
        chk("async reset pc_write", {31'd0, pc_write}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(v(4'hC, 0, 1, 2, 3, 0, 0, 1, 0, 0));
        @(posedge clk);
        #1;
        chk("post reset ALUOp_o", {28'd0, ALUOp_o}, 32'hC);
        chk("post reset bubble_o", {31'd0, bubble_o}, 32'd0);
        chk("post reset bubble_cnt", {16'd0, bubble_cnt}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
